// File: rtl/sum_acc_pkg.sv
// ----------------------------------------------------------------------------
// sum_acc_pkg
//   Shared definitions for the sum accumulator slice: FSM state encoding,
//   default widths and helpers for the signed saturation limits.
//   No ports (package).
// ----------------------------------------------------------------------------
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_IN_W        = 6;
    localparam int DEF_ACC_W       = 10;
    localparam int DEF_NUM_SAMPLES = 8;

    // Largest positive value of a w-bit signed word: +2^(w-1)-1.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative value of a w-bit signed word: -2^(w-1).
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// ----------------------------------------------------------------------------
// sum_acc_if
//   Handshake bundle around the accumulator: sample input stream
//   (in_valid/in_ready/in_sum) and result output stream
//   (out_valid/out_ready/out_acc/out_ovf).
//   slave  : the accumulator side (consumes samples, produces results)
//   master : the producer/consumer side connected to it
// ----------------------------------------------------------------------------
interface sum_acc_if
    import sum_acc_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_sum;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_acc;
    logic                    out_ovf;

    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );

    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/sum_accumulator_acc_sat_add.sv
// ----------------------------------------------------------------------------
// acc_sat_add
//   Combinational accumulate step: sign-extends the incoming sum to the
//   accumulator width, adds it and flags signed overflow.
//   Build option: ACC_SATURATE_EN defined -> the result clamps to the signed
//   limits on overflow; undefined -> two's-complement wrap-around.
// Ports
//   acc      in   ACC_W  current accumulator value (signed)
//   in_sum   in   IN_W   incoming sample (signed)
//   acc_next out  ACC_W  updated accumulator value
//   ovf      out  1      signed overflow in this addition
// ----------------------------------------------------------------------------
module acc_sat_add
    import sum_acc_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W
)
(
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [IN_W-1:0]  in_sum,
    output logic signed [ACC_W-1:0] acc_next,
    output logic                    ovf
);

    // Sized cast of a signed operand sign-extends.
    function automatic logic signed [ACC_W-1:0] sext(input logic signed [IN_W-1:0] v);
        return ACC_W'(v);
    endfunction

`ifdef ACC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    // On overflow the wrapped sign is the opposite of the true sign, so a
    // negative-looking raw result means the true value went past +max.
    function automatic logic signed [ACC_W-1:0] saturate(
        input logic signed [ACC_W-1:0] raw,
        input logic                    o
    );
        if (!o)
            return raw;
        return raw[ACC_W-1] ? SAT_MAX : SAT_MIN;
    endfunction
`endif

    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] raw;

    always_comb begin
        ext = sext(in_sum);
        raw = acc + ext;
        ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef ACC_SATURATE_EN
        acc_next = saturate(raw, ovf);
`else
        acc_next = raw;
`endif
    end

endmodule

// File: rtl/sum_accumulator.sv
// ----------------------------------------------------------------------------
// sum_accumulator
//   Accumulates NUM_SAMPLES signed sums from the adder stage into a wider
//   signed register and presents the total as one result word with a sticky
//   overflow flag.
//   Build option: ACC_SATURATE_EN (saturating accumulation, see acc_sat_add).
// Ports
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous active-high reset
//   clear  in   1   synchronous abort/restart (below rst, above all else)
//   busy   out  1   accumulation in progress or result pending
//   bus    slave    in_valid/in_ready/in_sum, out_valid/out_ready/out_acc/out_ovf
// ----------------------------------------------------------------------------
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int IN_W        = DEF_IN_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
)
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clear,
    output logic    busy,
    sum_acc_if.slave bus
);

    localparam int               CNT_W    = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    state_t                  state;
    state_t                  state_next;
    logic signed [ACC_W-1:0] acc;
    logic        [CNT_W-1:0] cnt;
    logic                    ovf_sticky;
    logic signed [ACC_W-1:0] res_acc;
    logic                    res_ovf;

    logic                    xfer;
    logic                    last;
    logic signed [ACC_W-1:0] acc_next;
    logic                    ovf_this;

    acc_sat_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc      (acc),
        .in_sum   (bus.in_sum),
        .acc_next (acc_next),
        .ovf      (ovf_this)
    );

    // in_ready depends on state alone, so the transfer term has no path
    // back through the handshake outputs.
    always_comb begin
        xfer = bus.in_valid && (state != DONE);
        last = (cnt == LAST_CNT);
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b1;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        unique case (state)
            IDLE: begin
                // With NUM_SAMPLES==1 the first sample is also the last.
                if (xfer)
                    state_next = last ? DONE : ACCUM;
            end
            ACCUM: begin
                busy = 1'b1;
                if (xfer && last)
                    state_next = DONE;
            end
            DONE: begin
                busy          = 1'b1;
                bus.in_ready  = 1'b0;
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulate stage -> result register boundary
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            res_ovf    <= 1'b0;
            // clear drops a pending result but leaves the last word visible.
            if (rst)
                res_acc <= '0;
        end else begin
            state <= state_next;
            if (xfer) begin
                if (last) begin
                    res_acc    <= acc_next;
                    res_ovf    <= ovf_sticky | ovf_this;
                    acc        <= '0;
                    cnt        <= '0;
                    ovf_sticky <= 1'b0;
                end else begin
                    acc        <= acc_next;
                    cnt        <= cnt + CNT_W'(1);
                    ovf_sticky <= ovf_sticky | ovf_this;
                end
            end else if ((state == DONE) && bus.out_ready) begin
                res_ovf <= 1'b0;
            end
        end
    end

    assign bus.out_acc = res_acc;
    assign bus.out_ovf = res_ovf;

endmodule
